multicycle_core: RTL
====================

// Module: multicycle_core
// PURPOSE
//  Parametrised multicycle successor to the single-cycle 8-bit processor: FSM-sequenced fetch/execute/writeback.
//  Adds a loadable instruction memory, LDI, SUB, conditional jump (JZ), HALT, Z/C flags and a start/halted handshake.
//  Sits under the tt_um top wrapper; a host loads the program, pulses start, then observes the writeback bus.
// PARAMETERS
//  DATA_W   8  datapath and register width
//  REG_AW   2  register address bits; register file holds 2**REG_AW registers
//  PC_W     4  PC bits; IMEM depth is 2**PC_W; requires PC_W <= 2*REG_AW
//  INSTR_W  3+3*REG_AW  derived, localparam; 9 at defaults
// PORTS
//  clk        in   1        clock
//  rst        in   1        asynchronous, active-high reset
//  start      in   1        run request; honoured only in IDLE/HALTED
//  imem_we    in   1        IMEM write strobe; honoured only in IDLE/HALTED
//  imem_waddr in   PC_W     IMEM write address
//  imem_wdata in   INSTR_W  IMEM write data
//  dbg_raddr  in   REG_AW   debug register read address
//  dbg_rdata  out  DATA_W   combinational read of regs[dbg_raddr]
//  busy       out  1        high in FETCH/EXEC/WB
//  halted     out  1        high in HALTED
//  pc         out  PC_W     current PC
//  flag_z     out  1        zero flag
//  flag_c     out  1        carry / borrow flag
//  wb_valid   out  1        one-cycle pulse when a register is written
//  wb_addr    out  REG_AW   destination of that write
//  wb_data    out  DATA_W   data of that write
// BEHAVIOUR
//  Reset: state=IDLE; pc, flags, all registers, IR, result = 0; all outputs 0. IMEM is not reset.
//  Format: [INSTR_W-1 -: 3]=op, then rs1, rs2, rd (REG_AW bits each, MSB to LSB).
//  Opcodes:
//   000 ADD  rd=rs1+rs2; C=carry-out
//   001 SUB  rd=rs1-rs2; C=borrow (rs1<rs2)
//   010 AND  rd=rs1&rs2; C=0
//   011 OR   rd=rs1|rs2; C=0
//   100 LDI  rd=zero-extended {rs1,rs2}; C unchanged
//   101 JMP  pc = low PC_W bits of {rs1,rs2,rd}
//   110 JZ   pc = target if Z=1, else pc+1
//   111 HALT
//  Arithmetic is mod 2**DATA_W. Z = (result==0) for ALU ops and LDI. JMP, JZ and HALT leave flags unchanged.
//  FSM: IDLE -start-> FETCH (pc=0); FETCH: IR<=imem[pc] -> EXEC; EXEC: read regs, compute result/flags -> WB;
//   WB: write rd, update flags, pc<=next -> FETCH; HALT in WB -> HALTED (pc holds at the HALT address).
//   HALTED -start-> FETCH with pc=0. Each instruction takes exactly 3 cycles.
//  wb_valid is asserted during WB for ALU ops and LDI only. The register write and flag update occur at the end of WB.
//  PC increment wraps from 2**PC_W-1 to 0.
//  start or imem_we while busy: ignored, no side effects.
//  imem_we and start in the same IDLE cycle: the write lands at that edge; the following FETCH sees the new word.
//  rst mid-instruction: any in-flight write is aborted. IMEM contents are retained.
//  rs1==rs2 or rd==rs: reads use pre-WB values.
// STRUCTURE
//  Package multicycle_core_pkg: opcode localparams; state enum {IDLE, FETCH, EXEC, WB, HALTED}.
//  Sub-module core_regfile: 2 async read ports plus 1 debug read port, 1 sync write port, async clear on rst.
//  IMEM is an inferred array inside the core; ALU is an always_comb block inside the core.
// TESTING (defaults; encodings are 9-bit)
//  LDI r1,#5; LDI r2,#3; ADD r1,r2,r3; HALT
//   -> wb pulses r1=05, r2=03, r3=08; halted 12 cycles after start accepted; Z=0, C=0
//  LDI r0,#0; LDI r1,#1; SUB r0,r1,r2; ADD r2,r1,r3
//   -> r2=FF with C=1, Z=0; then r3=00 with C=1, Z=1
//  SUB r1,r1,r1 then JZ to 0xA
//   -> Z=1, pc=0xA at the next FETCH; repeat with Z=0 -> pc advances by 1
//  IMEM filled with OR r0,r0,r0 (no HALT)
//   -> pc sequence 0..F, 0, 1 (wrap); busy never drops
//  During a run: pulse start and imem_we to address 3
//   -> PC and IMEM[3] unchanged; after HALT, a new start re-runs from pc=0
//  Assert rst in EXEC of ADD
//   -> immediately IDLE, regs = 0, wb_valid = 0; IMEM readback is unchanged after restart

Source files
------------

// File: rtl/multicycle_core_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM state encoding
// and the decode helper that tells which opcodes write the register file.
package multicycle_core_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_LDI  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_JZ   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_WB     = 3'd3;
  localparam state_t ST_HALTED = 3'd4;

  function automatic logic writes_reg(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Host-side bus of the multicycle core: program load, run handshake,
// debug register read, status and the writeback observation bus.
interface multicycle_core_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int PC_W   = 4
);
  localparam int INSTR_W = 3 + 3 * REG_AW;

  logic               start;
  logic               imem_we;
  logic [PC_W-1:0]    imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic [REG_AW-1:0]  dbg_raddr;
  logic [DATA_W-1:0]  dbg_rdata;
  logic               busy;
  logic               halted;
  logic [PC_W-1:0]    pc;
  logic               flag_z;
  logic               flag_c;
  logic               wb_valid;
  logic [REG_AW-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;

  modport master (
    output start, imem_we, imem_waddr, imem_wdata, dbg_raddr,
    input  dbg_rdata, busy, halted, pc, flag_z, flag_c,
           wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  start, imem_we, imem_waddr, imem_wdata, dbg_raddr,
    output dbg_rdata, busy, halted, pc, flag_z, flag_c,
           wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/multicycle_core_regfile.sv
// Register file for the multicycle core: two operand read ports, one debug
// read port, one synchronous write port, cleared by the asynchronous reset.
module core_regfile
  import multicycle_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);
  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] regs [NREG];

  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // this small array is flop-based and cleared on reset, whereas IMEM stays unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a   = regs[raddr_a];
  assign rdata_b   = regs[raddr_b];
  assign dbg_rdata = regs[dbg_raddr];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle 8-bit processor: FETCH/EXEC/WB sequencing over a host-loadable
// instruction memory, with Z/C flags and a start/halted handshake.
module multicycle_core
  import multicycle_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int PC_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_core_if.slave bus
);
  localparam int INSTR_W = 3 + 3 * REG_AW;
  localparam int DEPTH   = 2 ** PC_W;

  logic [INSTR_W-1:0] imem [DEPTH];

  state_t             state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    next_pc;
  logic [PC_W-1:0]    target;
  logic [INSTR_W-1:0] ir;
  logic [2:0]         op;
  logic [REG_AW-1:0]  rs1;
  logic [REG_AW-1:0]  rs2;
  logic [REG_AW-1:0]  rd;
  logic [DATA_W-1:0]  rdata_a;
  logic [DATA_W-1:0]  rdata_b;
  logic [DATA_W-1:0]  alu_res;
  logic [DATA_W-1:0]  result;
  logic [DATA_W:0]    sum;
  logic               alu_c;
  logic               alu_z;
  logic               res_z;
  logic               res_c;
  logic               flag_z;
  logic               flag_c;
  logic               reg_we;
  logic               accepting;

  assign op     = ir[INSTR_W-1 -: 3];
  assign rs1    = ir[3*REG_AW-1 -: REG_AW];
  assign rs2    = ir[2*REG_AW-1 -: REG_AW];
  assign rd     = ir[REG_AW-1:0];
  assign target = ir[PC_W-1:0];

  // Host requests are only honoured while the core is parked.
  assign accepting = (state == ST_IDLE) || (state == ST_HALTED);
  assign reg_we    = (state == ST_WB) && writes_reg(op);

  always_ff @(posedge clk) begin
    if (bus.imem_we && accepting) imem[bus.imem_waddr] <= bus.imem_wdata;
  end

  core_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr_a   (rs1),
    .raddr_b   (rs2),
    .dbg_raddr (bus.dbg_raddr),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .dbg_rdata (bus.dbg_rdata),
    .we        (reg_we),
    .waddr     (rd),
    .wdata     (result)
  );

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch behind.
    alu_res = '0;
    alu_c   = flag_c;
    sum     = '0;
    case (op)
      OP_ADD: begin
        sum     = {1'b0, rdata_a} + {1'b0, rdata_b};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_SUB: begin
        alu_res = rdata_a - rdata_b;
        alu_c   = (rdata_a < rdata_b);
      end
      OP_AND: begin
        alu_res = rdata_a & rdata_b;
        alu_c   = 1'b0;
      end
      OP_OR: begin
        alu_res = rdata_a | rdata_b;
        alu_c   = 1'b0;
      end
      OP_LDI:  alu_res = DATA_W'({rs1, rs2});
      default: alu_res = '0;
    endcase
  end

  assign alu_z = (alu_res == '0);

  // JZ tests the committed Z flag; the branch itself never touches flags.
  always_comb begin
    next_pc = pc + PC_W'(1);
    if (op == OP_JMP || (op == OP_JZ && flag_z)) next_pc = target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      pc     <= '0;
      ir     <= '0;
      result <= '0;
      res_z  <= 1'b0;
      res_c  <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (bus.start) begin
            state <= ST_FETCH;
            pc    <= '0;
          end
        end
        ST_FETCH: begin
          ir    <= imem[pc];
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          result <= alu_res;
          res_z  <= alu_z;
          res_c  <= alu_c;
          state  <= ST_WB;
        end
        ST_WB: begin
          if (writes_reg(op)) begin
            flag_z <= res_z;
            flag_c <= res_c;
          end
          if (op == OP_HALT) begin
            state <= ST_HALTED;
          end else begin
            state <= ST_FETCH;
            pc    <= next_pc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_WB);
  assign bus.halted   = (state == ST_HALTED);
  assign bus.pc       = pc;
  assign bus.flag_z   = flag_z;
  assign bus.flag_c   = flag_c;
  assign bus.wb_valid = reg_we;
  assign bus.wb_addr  = rd;
  assign bus.wb_data  = result;

endmodule
